// File: rtl/alu_pkg.sv
// Shared opcode encodings and width default for the mini MIPS ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 3'b000;
  localparam alu_op_t ALU_SUB  = 3'b001;
  localparam alu_op_t ALU_AND  = 3'b010;
  localparam alu_op_t ALU_OR   = 3'b011;
  localparam alu_op_t ALU_XOR  = 3'b100;
  localparam alu_op_t ALU_NOR  = 3'b101;
  localparam alu_op_t ALU_SLT  = 3'b110;
  localparam alu_op_t ALU_RSVD = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, operand equality, zero and signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             equal,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  assign equal = (a == b);
  assign zero  = (result == '0);

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, outputs held while idle, async active-low reset.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             equal,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] core_result;
  logic             core_equal;
  logic             core_zero;
  logic             core_overflow;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             equal_q, equal_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .result   (core_result),
    .equal    (core_equal),
    .zero     (core_zero),
    .overflow (core_overflow)
  );

  // Data outputs hold their last value when no operation is issued.
  always_comb begin
    valid_d    = in_valid;
    result_d   = result_q;
    equal_d    = equal_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    if (in_valid) begin
      result_d   = core_result;
      equal_d    = core_equal;
      zero_d     = core_zero;
      overflow_d = core_overflow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      equal_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      equal_q    <= equal_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign equal     = equal_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Directed and randomised scoreboard bench for the registered ALU.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b;
  logic [2:0]  alu_op;
  logic        out_valid;
  logic [31:0] result;
  logic        equal, zero, overflow;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .result    (result),
    .equal     (equal),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] r;
    logic        eq;
    logic        z;
    logic        ov;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  last_exp;
  int    n_cmp  = 0;
  int    n_fail = 0;

  function automatic exp_t mk(logic v, logic [31:0] r, logic eq, logic ov);
    exp_t e;
    e.v  = v;
    e.r  = r;
    e.eq = eq;
    e.z  = (r == 32'd0);
    e.ov = ov;
    return e;
  endfunction

  // Independent reference used for the randomised section.
  function automatic exp_t ref_alu(logic [31:0] x, logic [31:0] y, logic [2:0] op);
    logic [32:0] wide;
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    case (op)
      3'd0: begin
        wide = {1'b0, x} + {1'b0, y};
        r    = wide[31:0];
        ov   = ($signed(x) > 0 && $signed(y) > 0 && $signed(r) < 0) ||
               ($signed(x) < 0 && $signed(y) < 0 && $signed(r) >= 0);
      end
      3'd1: begin
        r  = x + (~y) + 32'd1;
        ov = ($signed(x) >= 0 && $signed(y) < 0 && $signed(r) < 0) ||
             ($signed(x) < 0 && $signed(y) >= 0 && $signed(r) >= 0);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = ~(x | y);
      3'd6: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return mk(1'b1, r, x == y, ov);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(string tag, exp_t e);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e.v});
    chk({tag, ".result"},    result,             e.r);
    chk({tag, ".equal"},     {31'd0, equal},     {31'd0, e.eq});
    chk({tag, ".zero"},      {31'd0, zero},      {31'd0, e.z});
    chk({tag, ".overflow"},  {31'd0, overflow},  {31'd0, e.ov});
  endtask

  // Drive one cycle of stimulus, push its expectation, then pop and compare after the edge.
  task automatic issue(logic v, logic [31:0] x, logic [31:0] y, logic [2:0] op,
                       exp_t e, string tag);
    exp_t  got_e;
    string got_t;
    exp_t  pe;
    in_valid = v;
    a        = x;
    b        = y;
    alu_op   = op;
    if (v) pe = e;
    else begin
      pe   = last_exp;
      pe.v = 1'b0;
    end
    exp_q.push_back(pe);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    got_t = tag_q.pop_front();
    chk_all(got_t, got_e);
    last_exp = got_e;
  endtask

  initial begin
    exp_t z0;
    z0 = mk(1'b0, 32'd0, 1'b0, 1'b0);
    z0.z = 1'b0;
    last_exp = z0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    alu_op   = '0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reset", z0);

    issue(1, 9999, 8111, ALU_ADD, mk(1, 32'd18110, 0, 0), "add");
    issue(1, 9999, 8111, ALU_SUB, mk(1, 32'd1888, 0, 0), "sub");
    issue(1, 9999, 8111, ALU_AND, mk(1, 32'd1807, 0, 0), "and");
    issue(1, 9999, 8111, ALU_OR,  mk(1, 32'd16303, 0, 0), "or");
    issue(1, 9999, 8111, ALU_XOR, mk(1, 32'd14496, 0, 0), "xor");
    issue(1, 9999, 8111, ALU_NOR, mk(1, 32'hFFFFC050, 0, 0), "nor");
    issue(1, 9999, 8111, ALU_SLT, mk(1, 32'd0, 0, 0), "slt_gt");

    issue(1, 8111, 8111, ALU_SLT, mk(1, 32'd0, 1, 0), "slt_eq");
    issue(1, 8111, 8311, ALU_SLT, mk(1, 32'd1, 0, 0), "slt_lt");
    issue(1, 32'hFFFFFFFF, 32'd1, ALU_SLT, mk(1, 32'd1, 0, 0), "slt_signed");

    issue(1, 8111, 8311, ALU_SUB, mk(1, 32'hFFFFFF38, 0, 0), "sub_neg");
    issue(1, 32'h7FFFFFFF, 32'hFFFFFFFF, ALU_SUB, mk(1, 32'h80000000, 0, 1), "sub_ovf");
    issue(1, 32'h7FFFFFFF, 32'd1, ALU_ADD, mk(1, 32'h80000000, 0, 1), "add_ovf");
    issue(1, 32'hFFFFFFFF, 32'd1, ALU_ADD, mk(1, 32'd0, 0, 0), "add_wrap");
    issue(1, 32'h80000000, 32'h80000000, ALU_ADD, mk(1, 32'd0, 1, 1), "add_negovf");
    issue(1, 32'h7FFFFFFF, 32'h7FFFFFFF, ALU_AND, mk(1, 32'h7FFFFFFF, 1, 0), "and_noovf");

    issue(1, 32'h12345678, 32'h0F0F0F0F, ALU_RSVD, mk(1, 32'd0, 0, 0), "rsvd");
    issue(0, 32'hDEADBEEF, 32'h1, ALU_OR, z0, "idle_hold");
    issue(1, 32'h5, 32'h5, ALU_OR, mk(1, 32'h5, 1, 0), "or_eq");
    issue(0, 32'h0, 32'h0, ALU_ADD, z0, "idle_hold2");

    // Reset in the middle of a cycle with an operation in flight.
    in_valid = 1'b1;
    a        = 32'd1;
    b        = 32'd2;
    alu_op   = ALU_ADD;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset", z0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_release", z0);
    last_exp = z0;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      logic [2:0]  op;
      x  = $urandom;
      y  = (i % 5 == 0) ? x : $urandom;
      if (i % 7 == 0) x[31] = y[31];
      op = 3'($urandom_range(0, 7));
      issue(1, x, y, op, ref_alu(x, y, op), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the mini MIPS datapath; executes one of seven operations selected by a 3-bit opcode.
- Also reports operand equality for branch resolution.
- Inputs are sampled and results registered on each clock edge, giving one cycle of latency.
- Sits between the register-file read stage and the writeback/branch logic.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  A, B and alu_op are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_op  input  3  operation select.
- out_valid  output  1  result and flags are valid (issued one cycle after in_valid).
- result  output  WIDTH  operation result.
- equal  output  1  1 when a == b (bitwise equality), independent of alu_op.
- zero  output  1  1 when result == 0.
- overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid, result, equal, zero and overflow all go to 0 immediately. They stay at 0 until the first valid input after rst_n is released.
- Opcodes:
  - 000 ADD: a+b, modulo 2^WIDTH.
  - 001 SUB: a-b, modulo 2^WIDTH.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOR.
  - 110 SLT: 1 if signed(a) < signed(b), else 0, zero-extended.
  - 111 reserved: result 0, overflow 0.
- Overflow:
  - ADD: set when a and b have the same sign and the result sign differs.
  - SUB: set when a and b have different signs and the result sign differs from a.
- Latency: inputs sampled at rising edge N with in_valid=1 produce all outputs after edge N, with out_valid=1 for exactly that cycle.
- in_valid=0 at an edge: out_valid goes 0; result/equal/zero/overflow hold their last values.
- Back-to-back: a new operation every cycle is accepted. There is no backpressure and no stall input.
- equal, zero and overflow are registered together with result, so all outputs are cycle-coherent.
- Reset asserted mid-stream: the in-flight result is discarded. out_valid=0 on the first edge after release unless in_valid=1 at that edge.
- Combinational core has no latches; every opcode, including 111, has a defined output.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants ALU_ADD..ALU_SLT and ALU_RSVD.
  - typedef alu_op_t (3-bit).
  - WIDTH default.
- One sub-module, alu_core: purely combinational.
  - Computes next result, equal, zero and overflow from a, b and alu_op.
  - The top-level alu adds the input-valid qualification and the output register stage with asynchronous reset.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> all outputs 0 immediately. Release with in_valid=0 -> outputs stay 0.
- a=9999, b=8111, ops 000..110 in consecutive cycles. One cycle later, out_valid=1 each cycle, equal=0, and results in order:
  - ADD 18110, SUB 1888, AND 1807, OR 16303, XOR 14496, NOR 0xFFFFC050, SLT 0.
- op=110, a=b=8111 -> equal=1, result=0, zero=1. Then a=8111, b=8311 -> equal=0, result=1.
- op=001, a=8111, b=8311 -> result=0xFFFFFF38, overflow=0. Then a=0x7FFFFFFF, b=0xFFFFFFFF -> result=0x80000000, overflow=1.
- op=000, a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1. Then a=0xFFFFFFFF, b=1 -> result=0, zero=1, overflow=0.
- op=111 with any operands -> result=0. Then drop in_valid -> out_valid=0 and result holds 0.
